// File: rtl/monster_controller.sv
// monster_controller: per-monster position, ALIVE/EXPLODING/DEAD lifecycle and pixel hit-test.
// Latency: offsets/InsideRectangle/monsterIsHit/monsterDead 1 cycle; position updates on the startOfFrame edge.
// Backpressure: none; accepts one pixel per clock with no stalls.
//
// Ports:
//   clk, reset (sync, active-high)   - single clock domain
//   startOfFrame                     - one-cycle pulse per video frame, paces movement and explosion
//   pixelX, pixelY                   - current scan coordinate
//   collision                        - player shot overlaps the monster this cycle
//   offsetX, offsetY                 - pixel offset inside the monster rectangle (0 when outside)
//   InsideRectangle                  - pixel inside the rectangle and monster not DEAD
//   monsterIsHit, monsterDead        - registered state decodes (EXPLODING / DEAD)
//   topLeftX, topLeftY               - current monster position
module monster_controller #(
    parameter int OBJECT_WIDTH     = 32,
    parameter int OBJECT_HEIGHT    = 32,
    parameter int INITIAL_X        = 100,
    parameter int INITIAL_Y        = 50,
    parameter int X_SPEED          = 2,
    parameter int DROP_Y           = 8,
    parameter int LEFT_LIMIT       = 0,
    parameter int RIGHT_LIMIT      = 607,
    parameter int EXPLOSION_FRAMES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        collision,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        InsideRectangle,
    output logic        monsterIsHit,
    output logic        monsterDead,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY
);

    localparam logic [1:0] ST_ALIVE     = 2'd0;
    localparam logic [1:0] ST_EXPLODING = 2'd1;
    localparam logic [1:0] ST_DEAD      = 2'd2;

    localparam int CW = (EXPLOSION_FRAMES < 1) ? 1 : $clog2(EXPLOSION_FRAMES + 1);

    localparam logic [11:0] C_SPEED      = 12'(X_SPEED);
    localparam logic [11:0] C_RIGHT      = 12'(RIGHT_LIMIT);
    localparam logic [11:0] C_LEFT_SPEED = 12'(LEFT_LIMIT + X_SPEED);
    localparam logic [10:0] C_RIGHT_11   = 11'(RIGHT_LIMIT);
    localparam logic [10:0] C_LEFT_11    = 11'(LEFT_LIMIT);
    localparam logic [10:0] C_SPEED_11   = 11'(X_SPEED);
    localparam logic [10:0] C_DROP_11    = 11'(DROP_Y);
    localparam logic [11:0] C_WIDTH      = 12'(OBJECT_WIDTH);
    localparam logic [11:0] C_HEIGHT     = 12'(OBJECT_HEIGHT);
    localparam logic [CW-1:0] C_CNT_INIT = CW'(EXPLOSION_FRAMES);

    logic [1:0]    r_state;
    logic          r_dir_left;
    logic [10:0]   r_x;
    logic [10:0]   r_y;
    logic [CW-1:0] r_cnt;
    logic [10:0]   r_offx;
    logic [10:0]   r_offy;
    logic          r_inside;
    logic          r_hit;
    logic          r_dead;

    logic [1:0]    w_state_nxt;
    logic          w_dir_nxt;
    logic [10:0]   w_x_nxt;
    logic [10:0]   w_y_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [11:0]   w_x_plus;
    logic [11:0]   w_x_end;
    logic [11:0]   w_y_end;
    logic          w_inside;

    // 12-bit sums so the right-limit and rectangle-end tests cannot wrap
    assign w_x_plus = {1'b0, r_x} + C_SPEED;
    assign w_x_end  = {1'b0, r_x} + C_WIDTH;
    assign w_y_end  = {1'b0, r_y} + C_HEIGHT;

    assign w_inside = (r_state != ST_DEAD)
                   && (pixelX >= r_x) && ({1'b0, pixelX} < w_x_end)
                   && (pixelY >= r_y) && ({1'b0, pixelY} < w_y_end);

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir_left;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_ALIVE: begin
                // A hit takes priority over the frame move in the same cycle
                if (collision) begin
                    w_state_nxt = ST_EXPLODING;
                    w_cnt_nxt   = C_CNT_INIT;
                end else if (startOfFrame) begin
                    if (!r_dir_left) begin
                        if (w_x_plus > C_RIGHT) begin
                            w_x_nxt   = C_RIGHT_11;
                            w_dir_nxt = 1'b1;
                            w_y_nxt   = r_y + C_DROP_11;
                        end else begin
                            w_x_nxt = w_x_plus[10:0];
                        end
                    end else begin
                        // Compare before subtracting so the position never underflows
                        if ({1'b0, r_x} < C_LEFT_SPEED) begin
                            w_x_nxt   = C_LEFT_11;
                            w_dir_nxt = 1'b0;
                            w_y_nxt   = r_y + C_DROP_11;
                        end else begin
                            w_x_nxt = r_x - C_SPEED_11;
                        end
                    end
                end
            end
            ST_EXPLODING: begin
                if (startOfFrame) begin
                    if (r_cnt <= CW'(1)) begin
                        w_state_nxt = ST_DEAD;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - CW'(1);
                    end
                end
            end
            default: begin
                // DEAD is terminal: everything held until reset
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_ALIVE;
            r_dir_left <= 1'b0;
            r_x        <= 11'(INITIAL_X);
            r_y        <= 11'(INITIAL_Y);
            r_cnt      <= '0;
            r_offx     <= '0;
            r_offy     <= '0;
            r_inside   <= 1'b0;
            r_hit      <= 1'b0;
            r_dead     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_dir_left <= w_dir_nxt;
            r_x        <= w_x_nxt;
            r_y        <= w_y_nxt;
            r_cnt      <= w_cnt_nxt;
            // Pixel test uses the pre-update position and state of this cycle
            r_inside   <= w_inside;
            r_offx     <= w_inside ? (pixelX - r_x) : 11'd0;
            r_offy     <= w_inside ? (pixelY - r_y) : 11'd0;
            // Decoded from the next state so the flags appear the cycle after the causing edge
            r_hit      <= (w_state_nxt == ST_EXPLODING);
            r_dead     <= (w_state_nxt == ST_DEAD);
        end
    end

    assign offsetX         = r_offx;
    assign offsetY         = r_offy;
    assign InsideRectangle = r_inside;
    assign monsterIsHit    = r_hit;
    assign monsterDead     = r_dead;
    assign topLeftX        = r_x;
    assign topLeftY        = r_y;

endmodule

// File: tb/tb_monster_controller.sv
// Testbench for monster_controller: table-driven pixel vectors plus directed lifecycle sequences.
// Latency: checks sample outputs 1 time unit after the rising edge that follows each stimulus.
// Backpressure: not applicable; stimulus is applied every cycle.
module tb_monster_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        startOfFrame;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        collision;
    logic        collision_e;

    logic [10:0] offsetX, offsetY, topLeftX, topLeftY;
    logic        InsideRectangle, monsterIsHit, monsterDead;

    logic [10:0] e_offsetX, e_offsetY, e_topLeftX, e_topLeftY;
    logic        e_InsideRectangle, e_monsterIsHit, e_monsterDead;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    monster_controller dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
        .pixelX(pixelX), .pixelY(pixelY), .collision(collision),
        .offsetX(offsetX), .offsetY(offsetY), .InsideRectangle(InsideRectangle),
        .monsterIsHit(monsterIsHit), .monsterDead(monsterDead),
        .topLeftX(topLeftX), .topLeftY(topLeftY)
    );

    // Second instance starting near the right limit to exercise the bounce
    monster_controller #(.INITIAL_X(604)) dut_edge (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
        .pixelX(pixelX), .pixelY(pixelY), .collision(collision_e),
        .offsetX(e_offsetX), .offsetY(e_offsetY), .InsideRectangle(e_InsideRectangle),
        .monsterIsHit(e_monsterIsHit), .monsterDead(e_monsterDead),
        .topLeftX(e_topLeftX), .topLeftY(e_topLeftY)
    );

    typedef struct {
        logic [10:0] px;
        logic [10:0] py;
        logic        exp_inside;
        logic [10:0] exp_offx;
        logic [10:0] exp_offy;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Vectors relative to reset position (100,50), 32x32 rectangle
        vecs[0] = '{11'd132, 11'd50, 1'b0, 11'd0,  11'd0};
        vecs[1] = '{11'd131, 11'd81, 1'b1, 11'd31, 11'd31};
        vecs[2] = '{11'd100, 11'd50, 1'b1, 11'd0,  11'd0};
        vecs[3] = '{11'd99,  11'd60, 1'b0, 11'd0,  11'd0};
        vecs[4] = '{11'd120, 11'd82, 1'b0, 11'd0,  11'd0};
        vecs[5] = '{11'd120, 11'd49, 1'b0, 11'd0,  11'd0};
        vecs[6] = '{11'd115, 11'd70, 1'b1, 11'd15, 11'd20};

        reset = 1'b1;
        startOfFrame = 1'b0;
        pixelX = 11'd0;
        pixelY = 11'd0;
        collision = 1'b0;
        collision_e = 1'b0;
        tick();
        tick();

        // Reset state (still in reset)
        check("rst_inside", int'(InsideRectangle), 0);
        check("rst_offx",   int'(offsetX), 0);
        check("rst_offy",   int'(offsetY), 0);
        check("rst_hit",    int'(monsterIsHit), 0);
        check("rst_dead",   int'(monsterDead), 0);
        check("rst_x",      int'(topLeftX), 100);
        check("rst_y",      int'(topLeftY), 50);
        check("rst_edge_x", int'(e_topLeftX), 604);
        reset = 1'b0;

        // Rectangle test table at the reset position
        for (int i = 0; i < 7; i++) begin
            pixelX = vecs[i].px;
            pixelY = vecs[i].py;
            tick();
            check($sformatf("vec%0d_inside", i), int'(InsideRectangle), int'(vecs[i].exp_inside));
            check($sformatf("vec%0d_offx", i),   int'(offsetX), int'(vecs[i].exp_offx));
            check($sformatf("vec%0d_offy", i),   int'(offsetY), int'(vecs[i].exp_offy));
        end

        // Three frames: main instance 100->106, edge instance bounces at 607
        frame();
        check("f1_x", int'(topLeftX), 102);
        check("f1_edge_x", int'(e_topLeftX), 606);
        check("f1_edge_y", int'(e_topLeftY), 50);
        frame();
        check("f2_x", int'(topLeftX), 104);
        check("f2_edge_x", int'(e_topLeftX), 607);
        check("f2_edge_y", int'(e_topLeftY), 58);
        frame();
        check("f3_x", int'(topLeftX), 106);
        check("f3_y", int'(topLeftY), 50);
        check("f3_edge_x", int'(e_topLeftX), 605);
        check("f3_edge_y", int'(e_topLeftY), 58);

        pixelX = 11'd110;
        pixelY = 11'd60;
        tick();
        check("moved_inside", int'(InsideRectangle), 1);
        check("moved_offx",   int'(offsetX), 4);
        check("moved_offy",   int'(offsetY), 10);

        // Pixel sampled on the same edge as a move uses the old position (106)
        pixelX = 11'd106;
        pixelY = 11'd50;
        frame();
        check("oldpos_inside", int'(InsideRectangle), 1);
        check("oldpos_offx",   int'(offsetX), 0);
        check("newpos_x",      int'(topLeftX), 108);

        // Collision -> EXPLODING, 15 frames stay, 16th -> DEAD
        pixelX = 11'd110;
        pixelY = 11'd60;
        collision = 1'b1;
        tick();
        collision = 1'b0;
        check("hit_rise", int'(monsterIsHit), 1);
        check("hit_dead", int'(monsterDead), 0);
        for (int f = 1; f <= 15; f++) begin
            frame();
            check($sformatf("expl_f%0d_hit", f), int'(monsterIsHit), 1);
            check($sformatf("expl_f%0d_x", f),   int'(topLeftX), 108);
        end
        frame();
        check("dead_flag", int'(monsterDead), 1);
        check("dead_hit",  int'(monsterIsHit), 0);
        check("dead_x",    int'(topLeftX), 108);
        tick();
        check("dead_inside_a", int'(InsideRectangle), 0);
        pixelX = 11'd108;
        pixelY = 11'd50;
        tick();
        check("dead_inside_b", int'(InsideRectangle), 0);
        check("dead_offx",     int'(offsetX), 0);
        collision = 1'b1;
        frame();
        collision = 1'b0;
        tick();
        check("dead_coll_dead", int'(monsterDead), 1);
        check("dead_coll_hit",  int'(monsterIsHit), 0);
        check("dead_coll_x",    int'(topLeftX), 108);

        // Collision together with startOfFrame: hit wins, no move
        do_reset();
        collision = 1'b1;
        startOfFrame = 1'b1;
        tick();
        collision = 1'b0;
        startOfFrame = 1'b0;
        check("sim_hit", int'(monsterIsHit), 1);
        check("sim_x",   int'(topLeftX), 100);

        // Reset during EXPLODING, with a collision in the same cycle
        frame();
        reset = 1'b1;
        collision = 1'b1;
        tick();
        reset = 1'b0;
        collision = 1'b0;
        check("rx_hit",  int'(monsterIsHit), 0);
        check("rx_dead", int'(monsterDead), 0);
        check("rx_x",    int'(topLeftX), 100);
        check("rx_y",    int'(topLeftY), 50);
        frame();
        check("rx_alive_move", int'(topLeftX), 102);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
